// File: rtl/synch_fifo_param_pkg.sv
// Shared helpers for the single-clock FIFO family.
//   fifo_clog2 : ceil(log2(n)), usable in constant expressions
//   fifo_pow2  : true when n is a power of two and >= 2
//   `FIFO_PTR_W(depth) : pointer width (index bits + wrap bit); the async FIFO
//                        will use the same pointer layout.
package synch_fifo_param_pkg;

  function automatic int fifo_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit fifo_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`ifndef FIFO_PTR_W
`define FIFO_PTR_W(depth) (synch_fifo_param_pkg::fifo_clog2(depth) + 1)
`endif

// File: rtl/synch_fifo_param_mem.sv
// Storage array for synch_fifo_param.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index (asynchronous read)
//   rdata : word at raddr
// No reset: contents are only meaningful behind the FIFO's pointers.
module synch_fifo_param_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/synch_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty, overflow/underflow pulses and optional
// first-word-fall-through read mode.
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-low reset
//   w_en, din    : write request and data
//   r_en         : read request (FWFT=1: pop the head word)
//   dout         : read data
//   full, empty, almost_full, almost_empty : decoded from count
//   count        : occupancy 0..DEPTH
//   overflow     : 1-cycle pulse, write rejected because full
//   underflow    : 1-cycle pulse, read rejected because empty
module synch_fifo_param
  import synch_fifo_param_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [DATA_W-1:0]      din,
  input  logic                   r_en,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = fifo_clog2(DEPTH);
  localparam int PTR_W  = `FIFO_PTR_W(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  if (DATA_W < 1) begin : g_bad_width
    $error("synch_fifo_param: DATA_W must be >= 1");
  end
  if (!fifo_pow2(DEPTH)) begin : g_bad_depth
    $error("synch_fifo_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("synch_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("synch_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rdata;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // Acceptance uses pre-edge flags: no bypass at either boundary.
  assign wr_ok = w_en & ~full;
  assign rd_ok = r_en & ~empty;

  synch_fifo_param_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (din),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      overflow  <= w_en & full;
      underflow <= r_en & empty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so the
    // uninitialised array never leaks onto dout.
    assign dout = empty ? '0 : rdata;
  end else begin : g_reg
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       dout_q <= '0;
      else if (rd_ok) dout_q <= rdata;
    end

    assign dout = dout_q;
  end

endmodule

// File: tb/tb_synch_fifo_param.sv
module tb_synch_fifo_param;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] din;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [3:0] cnt0, cnt1;

  int nvec;
  int nerr;

  synch_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  synch_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .din(din), .r_en(r_en), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Status of both instances: {full, empty, af, ae, ovf, udf} and count.
  task automatic chk_stat(input string tag, input logic [3:0] ecnt, input logic [5:0] eflags);
    chk({tag, " cnt0"}, 32'(cnt0), 32'(ecnt));
    chk({tag, " cnt1"}, 32'(cnt1), 32'(ecnt));
    chk({tag, " flg0"}, 32'({full0, empty0, af0, ae0, ovf0, udf0}), 32'(eflags));
    chk({tag, " flg1"}, 32'({full1, empty1, af1, ae1, ovf1, udf1}), 32'(eflags));
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    w_en = w;
    r_en = r;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags_for(input int c, input logic ov, input logic un);
    return {c == 8, c == 0, c >= 6, c <= 2, ov, un};
  endfunction

  logic [7:0] exp_d;

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b0;
    w_en = 1'b0;
    r_en = 1'b0;
    din  = 8'h00;
    #1;
    // 1: reset holds with random traffic
    chk_stat("rst_async", 4'd0, 6'b010100);
    chk("rst_async dout0", 32'(dout0), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      chk_stat("rst_hold", 4'd0, 6'b010100);
      chk("rst_hold dout0", 32'(dout0), 32'h0);
      chk("rst_hold dout1", 32'(dout1), 32'h0);
    end
    w_en = 1'b0;
    r_en = 1'b0;
    #2;
    rst = 1'b1;

    // 2: read while empty
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk_stat("rd_empty", 4'd0, 6'b010101);
      chk("rd_empty dout0", 32'(dout0), 32'h0);
    end
    step(1'b0, 1'b0, 8'h00);
    chk_stat("rd_empty_clr", 4'd0, 6'b010100);

    // 3: fill 0..7, then rejected write
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk_stat("fill", 4'(i + 1), flags_for(i + 1, 1'b0, 1'b0));
      chk("fill head1", 32'(dout1), 32'h0);
    end
    step(1'b1, 1'b0, 8'hAA);
    chk_stat("ovf", 4'd8, 6'b101010);
    step(1'b0, 1'b0, 8'h00);
    chk_stat("ovf_clr", 4'd8, 6'b101000);

    // 4: drain
    for (int i = 0; i < 8; i++) begin
      chk("drain head1", 32'(dout1), 32'(i));
      step(1'b0, 1'b1, 8'h00);
      chk("drain dout0", 32'(dout0), 32'(i));
      chk_stat("drain", 4'(7 - i), flags_for(7 - i, 1'b0, 1'b0));
    end

    // 5: wrap, 3 rounds of 5 in / 5 out
    for (int rd = 0; rd < 3; rd++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + rd * 5 + i));
      chk_stat("wrap peak", 4'd5, flags_for(5, 1'b0, 1'b0));
      for (int i = 0; i < 5; i++) begin
        exp_d = 8'(8'h10 + rd * 5 + i);
        chk("wrap head1", 32'(dout1), 32'(exp_d));
        step(1'b0, 1'b1, 8'h00);
        chk("wrap dout0", 32'(dout0), 32'(exp_d));
      end
      chk_stat("wrap end", 4'd0, 6'b010100);
    end

    // 6a: steady state at count 4
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      exp_d = (i < 4) ? 8'(8'h20 + i) : 8'(8'h30 + i - 4);
      chk("simul head1", 32'(dout1), 32'(exp_d));
      step(1'b1, 1'b1, 8'(8'h30 + i));
      chk("simul dout0", 32'(dout0), 32'(exp_d));
      chk_stat("simul", 4'd4, 6'b000000);
    end
    // contents now 36..39; top up to full with 40..43
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    chk_stat("refill", 4'd8, 6'b101000);

    // 6b: both at full
    step(1'b1, 1'b1, 8'hEE);
    chk_stat("both_full", 4'd7, 6'b001010);
    chk("both_full dout0", 32'(dout0), 32'h36);
    chk("both_full head1", 32'(dout1), 32'h37);
    step(1'b0, 1'b0, 8'h00);
    chk_stat("both_full_clr", 4'd7, 6'b001000);
    for (int i = 0; i < 7; i++) begin
      exp_d = (i < 3) ? 8'(8'h37 + i) : 8'(8'h40 + i - 3);
      step(1'b0, 1'b1, 8'h00);
      chk("drain2 dout0", 32'(dout0), 32'(exp_d));
    end
    chk_stat("drain2 end", 4'd0, 6'b010100);

    // 6c: both at empty
    step(1'b1, 1'b1, 8'h55);
    chk_stat("both_empty", 4'd1, 6'b000101);
    chk("both_empty dout0", 32'(dout0), 32'h43);
    chk("both_empty head1", 32'(dout1), 32'h55);
    step(1'b0, 1'b0, 8'h00);
    chk_stat("both_empty_clr", 4'd1, 6'b000100);

    // 6d: reset mid-fill, no clock edge needed
    step(1'b1, 1'b0, 8'h66);
    step(1'b1, 1'b0, 8'h77);
    chk_stat("prerst", 4'd3, flags_for(3, 1'b0, 1'b0));
    w_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_stat("midrst", 4'd0, 6'b010100);
    chk("midrst dout0", 32'(dout0), 32'h0);
    chk("midrst dout1", 32'(dout1), 32'h0);
    #3;
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h99);
    chk_stat("post_rst", 4'd1, flags_for(1, 1'b0, 1'b0));
    chk("post_rst head1", 32'(dout1), 32'h99);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst dout0", 32'(dout0), 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
